rtc_bus_arbiter: RTL and testbench
==================================

# rtc_bus_arbiter

Round-robin arbiter and transfer sequencer that shares the single RTC register bus among `NUM_REQ` requesters. It accepts one request at a time, drives the two-phase select/enable bus protocol toward the RTC, waits for `ready`, and returns read data and completion to the winning requester. It rejects writes to unmapped RTC addresses before they reach the bus.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 8: bus address width.
- `DATA_W`, 32: bus data width.
- `TIMEOUT_CYC`, 16: ACCESS wait limit in cycles. Used only with `RTC_ARB_TIMEOUT_EN`.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  request, one bit per requester; held until its `done`.
- `req_write`  in  NUM_REQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data, same packing.
- `gnt`  out  NUM_REQ  one-cycle one-hot pulse when a request is accepted.
- `done`  out  NUM_REQ  one-cycle one-hot pulse at completion.
- `rsp_rdata`  out  DATA_W  read data; valid with `done`, held until next `done`.
- `rsp_err`  out  1  valid with `done`; 1 = rejected or aborted.
- `sel`, `enable`, `write`  out  1 each  RTC bus controls.
- `addr`  out  ADDR_W  RTC bus address.
- `wdata`  out  DATA_W  RTC bus write data.
- `rdata`  in  DATA_W  RTC read data.
- `ready`  in  1  RTC transfer complete.

## Operation
- States: IDLE, SETUP, ACCESS. Encoded as a package enum.
- IDLE:
  - If any `req` is set, pick the winner by round-robin: search starts at the requester after the last winner.
  - Latch the winner's write, addr and wdata. Pulse `gnt[winner]`.
  - Advance the pointer to the winner.
- Invalid write: a write whose address is not 0x00 (time), 0x04 (alarm) or 0x08 (add/sub) is rejected.
  - `done[winner]` pulses in the same cycle as `gnt`, with `rsp_err`=1.
  - `sel` is never asserted; state stays IDLE.
  - Reads to any address are legal.
- Valid request → SETUP: `sel`=1, `enable`=0; addr, write and wdata driven from the latched values.
- SETUP → ACCESS unconditionally: `sel`=1, `enable`=1.
- ACCESS, `ready`=1 sampled:
  - Capture `rdata` into `rsp_rdata` on a read; unchanged on a write.
  - Pulse `done[winner]` with `rsp_err`=0.
  - Drop `sel`/`enable`; go to IDLE.
- ACCESS, `ready`=0: hold all bus outputs stable.
- `ready` is ignored outside ACCESS.
- `req` bits that drop mid-transfer are ignored; the latched transfer completes.
- Bus outputs are stable from SETUP through ACCESS.

## Timing
- All outputs are registered.
- Reset values:
  - `gnt`, `done`, `rsp_err`, `sel`, `enable`, `write` = 0.
  - `addr`, `wdata`, `rsp_rdata` = 0.
  - State = IDLE; round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Request sampled in IDLE at edge t:
  - `gnt` and `sel` high after t+1.
  - `enable` high after t+2.
  - With `ready` high in the first ACCESS cycle, `done` pulses after t+3 with `sel`=0.
- Minimum turnaround is 3 cycles per transfer. Back-to-back requests spend one IDLE cycle between transfers.
- Simultaneous requests are served in round-robin order. With two requesters held continuously, grants alternate.
- Reset asserted mid-transfer: immediate return to reset values. No `done` is issued for the aborted transfer.

## Configuration
- `RTC_ARB_TIMEOUT_EN` defined:
  - A counter runs in ACCESS while `ready`=0.
  - After `TIMEOUT_CYC` consecutive wait cycles, the transfer aborts: `done`+`rsp_err`=1, `rsp_rdata`=0, `sel`/`enable` drop, state → IDLE.
  - The counter clears on entry to SETUP.
- Undefined: ACCESS waits indefinitely; `rsp_err` is raised only by invalid-address rejection.

## Structure
- Package `rtc_bus_pkg`:
  - Address constants `RTC_ADDR_TIME`=8'h00, `RTC_ADDR_ALARM`=8'h04, `RTC_ADDR_ADJ`=8'h08.
  - State enum `rtc_arb_state_t`.
  - Function `rtc_wr_addr_valid`.
- Sub-module `rtc_rr_picker`: combinational. Inputs `req` and the pointer; outputs one-hot winner and its index.

## Test plan
- Single read: requester 0 reads 0x00, `ready` returns with `rdata`=0x12345678 in the first ACCESS cycle → `done[0]` 3 cycles after request, `rsp_rdata`=0x12345678, `rsp_err`=0.
- Contention: both requesters hold write requests to 0x04 after reset → grants in order 0,1,0,1; `sel` never overlaps between transfers.
- Invalid write: requester 1 writes 0x0C → `gnt[1]` and `done[1]` in the same cycle, `rsp_err`=1, `sel` stays 0.
- Wait states: `ready` held low for 5 cycles in ACCESS → `addr`, `wdata`, `sel` and `enable` stable throughout; `done` on the cycle after `ready`.
- Timeout (macro on, `TIMEOUT_CYC`=16): `ready` never asserted → `done`+`rsp_err`=1 after 16 ACCESS cycles, `rsp_rdata`=0.
- Reset in ACCESS: assert `reset` low during ACCESS → all outputs 0 immediately, no `done`; after release, requester 0 wins first.

Source files
------------

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared RTC bus address map, arbiter state encoding and write-address check.
package rtc_bus_pkg;
  localparam logic [7:0] RTC_ADDR_TIME  = 8'h00;
  localparam logic [7:0] RTC_ADDR_ALARM = 8'h04;
  localparam logic [7:0] RTC_ADDR_ADJ   = 8'h08;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} rtc_arb_state_t;

  function automatic logic rtc_wr_addr_valid(input logic [31:0] a);
    return a == 32'(RTC_ADDR_TIME) || a == 32'(RTC_ADDR_ALARM) || a == 32'(RTC_ADDR_ADJ);
  endfunction
endpackage

// File: rtl/rtc_rr_picker.sv
// rtc_rr_picker: combinational round-robin pick, search starts just after the pointer.
module rtc_rr_picker #(
  parameter int NUM_REQ = 2,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IW-1:0]      idx_o
);
  int j;
  // Walk candidates farthest-first so the nearest requester after the pointer overwrites last
  always_comb begin
    win_o = '0;
    idx_o = '0;
    j = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[j]) begin
        win_o = '0;
        win_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
  end
endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin arbiter and select/enable transfer sequencer for the RTC bus.
// Define RTC_ARB_TIMEOUT_EN to abort an ACCESS that waits TIMEOUT_CYC cycles for ready.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  localparam int IW         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      sel_o,
  output logic                      enable_o,
  output logic                      write_o,
  output logic [ADDR_W-1:0]         addr_o,
  output logic [DATA_W-1:0]         wdata_o,
  input  logic [DATA_W-1:0]         rdata_i,
  input  logic                      ready_i
);
  rtc_arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_idx;
  logic [NUM_REQ-1:0] win, own_q, own_d, gnt_q, gnt_d, done_q, done_d;
  logic err_q, err_d, sel_q, sel_d, en_q, en_d, write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d, win_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, win_wdata;
  logic win_write, take, reject, finish, tmo;

  rtc_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx)
  );

  assign win_addr  = req_addr_i[win_idx*ADDR_W +: ADDR_W];
  assign win_wdata = req_wdata_i[win_idx*DATA_W +: DATA_W];
  assign win_write = req_write_i[win_idx];
  assign take      = state_q == ST_IDLE && |req_i;
  assign reject    = take && win_write && !rtc_wr_addr_valid(32'(win_addr));
  assign finish    = state_q == ST_ACCESS && (ready_i || tmo);

`ifdef RTC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;
  assign tmo = state_q == ST_ACCESS && !ready_i && tmo_q == CW'(TIMEOUT_CYC - 1);
  // Count ACCESS wait cycles; held at zero while idle so every transfer starts fresh
  always_comb tmo_d = state_q == ST_IDLE ? '0 : (state_q == ST_ACCESS && !ready_i) ? tmo_q + CW'(1) : tmo_q;
  // Wait counter register
  always_ff @(posedge clk or negedge reset)
    if (!reset) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      own_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

  // Next state: rejected writes never leave IDLE, SETUP always advances, ACCESS waits for ready
  always_comb
    state_d = take ? (reject ? ST_IDLE : ST_SETUP)
            : state_q == ST_SETUP ? ST_ACCESS
            : finish ? ST_IDLE : state_q;

  // Output next values: latch the winner on grant, pulse done/err at completion or rejection
  always_comb begin
    ptr_d   = take ? win_idx : ptr_q;
    own_d   = take ? win : own_q;
    write_d = take ? win_write : write_q;
    addr_d  = take ? win_addr : addr_q;
    wdata_d = take ? win_wdata : wdata_q;
    gnt_d   = take ? win : '0;
    done_d  = reject ? win : finish ? own_q : '0;
    err_d   = reject || (finish && !ready_i);
    sel_d   = state_d != ST_IDLE;
    en_d    = state_d == ST_ACCESS;
    rdata_d = finish ? (ready_i ? (write_q ? rdata_q : rdata_i) : '0) : rdata_q;
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rsp_err_o   = err_q;
  assign rsp_rdata_o = rdata_q;
  assign sel_o       = sel_q;
  assign enable_o    = en_q;
  assign write_o     = write_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed table-driven bench for rtc_bus_arbiter (two requesters).
module tb_rtc_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [1:0] req_i = '0, req_write_i = '0;
  logic [15:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [1:0] gnt_o, done_o;
  logic [31:0] rsp_rdata_o, wdata_o;
  logic rsp_err_o, sel_o, enable_o, write_o;
  logic [7:0] addr_o;
  logic [31:0] rdata_i = '0;
  logic ready_i = 1'b0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        rej;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt[8];

  rtc_bus_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .sel_o       (sel_o),
    .enable_o    (enable_o),
    .write_o     (write_o),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rdata_i     (rdata_i),
    .ready_i     (ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_gnt"}, gnt_o, 0);
    chk({nm, "_done"}, done_o, 0);
    chk({nm, "_ctl"}, {rsp_err_o, sel_o, enable_o, write_o}, 0);
    chk({nm, "_addr"}, addr_o, 0);
    chk({nm, "_wdata"}, wdata_o, 0);
    chk({nm, "_rdata"}, rsp_rdata_o, 0);
  endtask

  task automatic drive(input int id, input logic wr, input logic [7:0] a, input logic [31:0] wd);
    req_write_i = '1;
    req_addr_i = '1;
    req_wdata_i = '1;
    req_write_i[id] = wr;
    req_addr_i[id*8 +: 8] = a;
    req_wdata_i[id*32 +: 32] = wd;
    req_i = '0;
    req_i[id] = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [1:0] exp_oh;
    exp_oh = 2'b01 << v.id;
    drive(v.id, v.wr, v.addr, v.wdata);
    rdata_i = v.rdata;
    ready_i = v.waits == 0;
    step;
    chk("gnt", gnt_o, exp_oh);
    if (v.rej) begin
      chk("rej_done", done_o, exp_oh);
      chk("rej_err", rsp_err_o, 1);
      chk("rej_sel", sel_o, 0);
      chk("rej_rdata", rsp_rdata_o, v.exp_rd);
      req_i = '0;
      step;
      chk("rej_idle_sel", {sel_o, gnt_o}, 0);
    end else begin
      chk("setup_sel_en", {sel_o, enable_o}, 2'b10);
      chk("setup_addr", addr_o, v.addr);
      chk("setup_write", write_o, v.wr);
      chk("setup_wdata", wdata_o, v.wdata);
      chk("setup_done", done_o, 0);
      step;
      chk("access_sel_en", {sel_o, enable_o}, 2'b11);
      chk("access_done", done_o, 0);
      for (int w = 0; w < v.waits; w++) begin
        step;
        chk("wait_ctl", {sel_o, enable_o, write_o}, {2'b11, v.wr});
        chk("wait_addr", addr_o, v.addr);
        chk("wait_wdata", wdata_o, v.wdata);
        chk("wait_done", done_o, 0);
        if (w == v.waits - 1) ready_i = 1'b1;
      end
      step;
      chk("done", done_o, exp_oh);
      chk("done_err", rsp_err_o, 0);
      chk("done_sel_en", {sel_o, enable_o}, 0);
      chk("rsp_rdata", rsp_rdata_o, v.exp_rd);
      req_i = '0;
      ready_i = 1'b0;
      step;
      chk("idle_done", done_o, 0);
    end
  endtask

  initial begin
    int n, dn, ng;
    logic prev_sel;
    vt[0] = '{0, 1'b0, 8'h00, 32'h0,        32'h12345678, 0, 1'b0, 32'h12345678};
    vt[1] = '{1, 1'b1, 8'h04, 32'hAABBCCDD, 32'hDEADBEEF, 0, 1'b0, 32'h12345678};
    vt[2] = '{1, 1'b1, 8'h0C, 32'h11112222, 32'h0,        0, 1'b1, 32'h12345678};
    vt[3] = '{0, 1'b1, 8'h08, 32'h000000FF, 32'h55555555, 5, 1'b0, 32'h12345678};
    vt[4] = '{1, 1'b0, 8'h3C, 32'h0,        32'hCAFEF00D, 2, 1'b0, 32'hCAFEF00D};
    vt[5] = '{0, 1'b1, 8'hFF, 32'h33334444, 32'h0,        0, 1'b1, 32'hCAFEF00D};
    vt[6] = '{0, 1'b1, 8'h00, 32'h00000001, 32'h77777777, 0, 1'b0, 32'hCAFEF00D};
    vt[7] = '{1, 1'b0, 8'h08, 32'h0,        32'h0BADF00D, 1, 1'b0, 32'h0BADF00D};

    step;
    step;
    chk_all_zero("reset");
    reset = 1'b1;
    step;
    chk("post_reset_idle", {gnt_o, sel_o}, 0);

    for (int k = 0; k < 8; k++) run_vec(vt[k]);

    drive(0, 1'b0, 8'h20, 32'h0);
    ready_i = 1'b0;
    step;
    chk("stall_gnt", gnt_o, 2'b01);
    step;
    chk("stall_access", {sel_o, enable_o}, 2'b11);
`ifdef RTC_ARB_TIMEOUT_EN
    n = 0;
    for (int c = 1; c <= 40 && n == 0; c++) begin
      step;
      if (done_o != 0) n = c;
    end
    chk("tmo_cycles", n, 16);
    chk("tmo_done", done_o, 2'b01);
    chk("tmo_err", rsp_err_o, 1);
    chk("tmo_rdata", rsp_rdata_o, 0);
    chk("tmo_sel_en", {sel_o, enable_o}, 0);
    req_i = '0;
    step;
    drive(1, 1'b0, 8'h14, 32'h0);
    step;
    step;
    chk("rst_pre_access", {sel_o, enable_o}, 2'b11);
`else
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      step;
      if (done_o != 0) dn++;
    end
    chk("hang_no_done", dn, 0);
    chk("hang_held", {sel_o, enable_o, addr_o}, {2'b11, 8'h20});
`endif

    req_i = '0;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step;
    chk("rst_no_done_a", done_o, 0);
    step;
    chk("rst_no_done_b", done_o, 0);
    reset = 1'b1;

    req_write_i = 2'b11;
    req_addr_i = {8'h04, 8'h04};
    req_wdata_i = {32'hB1B1B1B1, 32'hA0A0A0A0};
    ready_i = 1'b1;
    req_i = 2'b11;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      prev_sel = sel_o;
      step;
      if (gnt_o != 0) begin
        chk("cont_gnt", gnt_o, (ng % 2) ? 2'b10 : 2'b01);
        chk("cont_sel_gap", prev_sel, 0);
        ng++;
      end
    end
    chk("cont_count", ng, 4);
    req_i = '0;
    step;
    step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
